// File: rtl/frog_game_ctrl_if.sv
// Bundles the per-frame inputs and the game-state outputs of the frog controller.
// master = environment driving buttons/collisions, slave = the controller itself.
interface frog_game_ctrl_if;
  logic       frame_tick;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       death_collision;
  logic       win_collision;
  logic [9:0] frog_x;
  logic [9:0] frog_y;
  logic [2:0] lives;
  logic [3:0] level;
  logic       frog_visible;
  logic       game_over;

  modport master (
    output frame_tick, btn_up, btn_down, btn_left, btn_right,
    output death_collision, win_collision,
    input  frog_x, frog_y, lives, level, frog_visible, game_over
  );

  modport slave (
    input  frame_tick, btn_up, btn_down, btn_left, btn_right,
    input  death_collision, win_collision,
    output frog_x, frog_y, lives, level, frog_visible, game_over
  );
endinterface

// File: rtl/frog_game_ctrl.sv
// Frogger game-state controller: turns button presses into tile moves once per frame
// and sequences PLAY / DYING / WIN / GAME_OVER, tracking lives and level.
module frog_game_ctrl #(
  parameter int TILE_SIZE    = 32,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int START_X      = 320,
  parameter int START_Y      = 448,
  parameter int LIVES_INIT   = 3,
  parameter int DEATH_FRAMES = 60,
  parameter int WIN_FRAMES   = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  frog_game_ctrl_if.slave    gif
);
  localparam int CNT_MAX = (DEATH_FRAMES > WIN_FRAMES) ? DEATH_FRAMES : WIN_FRAMES;
  localparam int CNT_W   = ($clog2(CNT_MAX) < 3) ? 3 : $clog2(CNT_MAX);

  localparam logic [9:0]       START_X_V  = 10'(START_X);
  localparam logic [9:0]       START_Y_V  = 10'(START_Y);
  localparam logic [10:0]      TILE_V     = 11'(TILE_SIZE);
  localparam logic [10:0]      MAX_X_V    = 11'(SCREEN_W - TILE_SIZE);
  localparam logic [10:0]      MAX_Y_V    = 11'(SCREEN_H - TILE_SIZE);
  localparam logic [2:0]       LIVES_V    = 3'(LIVES_INIT);
  localparam logic [CNT_W-1:0] DEATH_LAST = CNT_W'(DEATH_FRAMES - 1);
  localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(WIN_FRAMES - 1);

  typedef enum logic [1:0] {S_PLAY, S_DYING, S_WIN, S_OVER} state_e;
  typedef enum logic [2:0] {MV_NONE, MV_UP, MV_DOWN, MV_LEFT, MV_RIGHT} move_e;

  state_e           state_q, state_d;
  move_e            pend_q, pend_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic [2:0]       lives_q, lives_d;
  logic [3:0]       level_q, level_d;
  logic             vis_q, vis_d, over_q, over_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       hist_q, hist_d;

  logic [3:0]  btn, rise;
  move_e       press;
  logic [10:0] x_ext, y_ext;

  // Bit order {up, down, left, right} doubles as the press priority.
  always_comb begin
    btn   = {gif.btn_up, gif.btn_down, gif.btn_left, gif.btn_right};
    rise  = btn & ~hist_q;
    x_ext = {1'b0, x_q};
    y_ext = {1'b0, y_q};
    press = MV_NONE;
    if (rise[3])      press = MV_UP;
    else if (rise[2]) press = MV_DOWN;
    else if (rise[1]) press = MV_LEFT;
    else if (rise[0]) press = MV_RIGHT;
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    x_d     = x_q;
    y_d     = y_q;
    lives_d = lives_q;
    level_d = level_q;
    vis_d   = vis_q;
    over_d  = over_q;
    cnt_d   = cnt_q;
    hist_d  = btn;

    unique case (state_q)
      S_PLAY: begin
        if (press != MV_NONE) pend_d = press;
        if (gif.frame_tick) begin
          if (gif.death_collision) begin
            state_d = S_DYING;
            cnt_d   = '0;
            pend_d  = MV_NONE;
            vis_d   = 1'b0;
          end else if (gif.win_collision) begin
            state_d = S_WIN;
            cnt_d   = '0;
            pend_d  = MV_NONE;
          end else begin
            // A press landing on the tick itself waits for the following frame.
            pend_d = press;
            case (pend_q)
              MV_UP:    if (y_ext >= TILE_V)           y_d = 10'(y_ext - TILE_V);
              MV_DOWN:  if (y_ext + TILE_V <= MAX_Y_V) y_d = 10'(y_ext + TILE_V);
              MV_LEFT:  if (x_ext >= TILE_V)           x_d = 10'(x_ext - TILE_V);
              MV_RIGHT: if (x_ext + TILE_V <= MAX_X_V) x_d = 10'(x_ext + TILE_V);
              default: ;
            endcase
          end
        end
      end

      S_DYING: begin
        if (gif.frame_tick) begin
          if (cnt_q == DEATH_LAST) begin
            lives_d = lives_q - 3'd1;
            pend_d  = MV_NONE;
            if (lives_q == 3'd1) begin
              state_d = S_OVER;
              vis_d   = 1'b0;
              over_d  = 1'b1;
            end else begin
              state_d = S_PLAY;
              x_d     = START_X_V;
              y_d     = START_Y_V;
              vis_d   = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            vis_d = cnt_d[2];
          end
        end
      end

      S_WIN: begin
        if (gif.frame_tick) begin
          if (cnt_q == WIN_LAST) begin
            level_d = (level_q == 4'd15) ? level_q : level_q + 4'd1;
            state_d = S_PLAY;
            pend_d  = MV_NONE;
            x_d     = START_X_V;
            y_d     = START_Y_V;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_OVER: begin
        if (|rise) begin
          state_d = S_PLAY;
          pend_d  = MV_NONE;
          lives_d = LIVES_V;
          level_d = 4'd0;
          x_d     = START_X_V;
          y_d     = START_Y_V;
          vis_d   = 1'b1;
          over_d  = 1'b0;
        end
      end
    endcase
  end

  // History resets high so a button held through reset is not seen as a press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_PLAY;
      pend_q  <= MV_NONE;
      x_q     <= START_X_V;
      y_q     <= START_Y_V;
      lives_q <= LIVES_V;
      level_q <= 4'd0;
      vis_q   <= 1'b1;
      over_q  <= 1'b0;
      cnt_q   <= '0;
      hist_q  <= 4'b1111;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      x_q     <= x_d;
      y_q     <= y_d;
      lives_q <= lives_d;
      level_q <= level_d;
      vis_q   <= vis_d;
      over_q  <= over_d;
      cnt_q   <= cnt_d;
      hist_q  <= hist_d;
    end
  end

  assign gif.frog_x       = x_q;
  assign gif.frog_y       = y_q;
  assign gif.lives        = lives_q;
  assign gif.level        = level_q;
  assign gif.frog_visible = vis_q;
  assign gif.game_over    = over_q;
endmodule
